// File: rtl/fourx1mux_arbiter_pkg.sv
// Shared definitions for the round-robin arbitrated 4:1 mux: FSM encodings
// and the requester-index to mux select-code table.
package fourx1mux_arbiter_pkg;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    // Packed table, entry i at bits [2*i+1:2*i]: 0->00, 1->10, 2->01, 3->11
    localparam logic [7:0] SEL_TABLE = {2'b11, 2'b01, 2'b10, 2'b00};

    function automatic logic [1:0] idx_to_sel(input logic [1:0] idx);
        return SEL_TABLE[{idx, 1'b0} +: 2];
    endfunction

endpackage

// File: rtl/fourx1mux.sv
// Legacy 4:1 data select; sel[0] picks the {c,d} pair, sel[1] picks within a pair.
module fourx1mux #(
    parameter int DATA_WIDTH = 4
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [DATA_WIDTH-1:0] c,
    input  logic [DATA_WIDTH-1:0] d,
    input  logic [1:0]            sel,
    output logic [DATA_WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        case (sel)
            2'b00:   y = a;
            2'b10:   y = b;
            2'b01:   y = c;
            default: y = d;
        endcase
    end

endmodule

// File: rtl/fourx1mux_arbiter.sv
// Round-robin arbiter over four requesters driving a shared fourx1mux into a
// registered valid/ready output stage.
module fourx1mux_arbiter
    import fourx1mux_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            req,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [DATA_WIDTH-1:0] c,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [3:0]            gnt,
    output logic [1:0]            sel,
    output logic [DATA_WIDTH-1:0] y,
    output logic                  out_valid,
    input  logic                  out_ready
);

    logic [0:0]            state;
    logic [1:0]            ptr;
    logic [1:0]            winner;
    logic [1:0]            idx;
    logic                  found;
    logic                  capture_en;
    logic                  capture;
    logic [1:0]            mux_sel;
    logic [DATA_WIDTH-1:0] mux_y;

    // Scan upward from ptr, wrapping; first requester seen wins.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int unsigned off = 0; off < 4; off++) begin
            idx = ptr + 2'(off);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign out_valid  = (state == HOLD);
    assign capture_en = (state == IDLE) | (out_ready & out_valid);
    assign capture    = capture_en & found;
    assign mux_sel    = idx_to_sel(winner);

    // Gated by rst_n so no grant escapes while the flops are held in reset.
    always_comb begin
        gnt = '0;
        if (capture && rst_n)
            gnt = 4'b0001 << winner;
    end

    fourx1mux #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_mux (
        .a  (a),
        .b  (b),
        .c  (c),
        .d  (d),
        .sel(mux_sel),
        .y  (mux_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
            y     <= '0;
            sel   <= 2'b00;
        end else if (capture) begin
            state <= HOLD;
            ptr   <= winner + 2'd1;
            y     <= mux_y;
            sel   <= mux_sel;
        end else if (state == HOLD && out_ready) begin
            state <= IDLE;
        end
    end

endmodule

// File: tb/tb_fourx1mux_arbiter.sv
// Directed-vector bench for fourx1mux_arbiter with hand-computed expectations.
module tb_fourx1mux_arbiter;
    import fourx1mux_arbiter_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] a, b, c, d;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic [3:0] y;
    logic       out_valid;
    logic       out_ready;

    int nvec = 0;
    int nmis = 0;

    fourx1mux_arbiter #(
        .DATA_WIDTH(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .a        (a),
        .b        (b),
        .c        (c),
        .d        (d),
        .gnt      (gnt),
        .sel      (sel),
        .y        (y),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: gnt checked mid-cycle, registered outputs checked after the edge.
    task automatic cyc(input string tag, input logic [3:0] eg, input logic [3:0] ey,
                       input logic [1:0] es, input logic eov);
        @(negedge clk);
        chk({tag, ".gnt"}, {4'h0, gnt}, {4'h0, eg});
        @(posedge clk);
        #1;
        chk({tag, ".y"},   {4'h0, y},   {4'h0, ey});
        chk({tag, ".sel"}, {6'h0, sel}, {6'h0, es});
        chk({tag, ".ov"},  {7'h0, out_valid}, {7'h0, eov});
    endtask

    initial begin
        rst_n = 1'b0; req = '0; out_ready = 1'b0;
        a = '0; b = '0; c = '0; d = '0;
        #2;
        chk("rst.ov",  {7'h0, out_valid}, {7'h0, IDLE});
        chk("rst.y",   {4'h0, y},   8'h00);
        chk("rst.sel", {6'h0, sel}, 8'h00);
        chk("rst.gnt", {4'h0, gnt}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single request from requester 2; out_ready low so the word is held.
        req = 4'b0100; c = 4'hC;
        cyc("r2", 4'b0100, 4'hC, 2'b01, HOLD);
        req = 4'b0000;
        cyc("r2hold", 4'b0000, 4'hC, 2'b01, HOLD);

        // Handshake with no request returns to IDLE; ptr stays at 3.
        out_ready = 1'b1;
        cyc("drain", 4'b0000, 4'hC, 2'b01, IDLE);

        // Wrap: ptr=3 so requester 3 beats 0, then requester 0 next.
        out_ready = 1'b0; req = 4'b1001; a = 4'h6; d = 4'h9;
        cyc("wrap3", 4'b1000, 4'h9, 2'b11, HOLD);
        out_ready = 1'b1;
        cyc("wrap0", 4'b0001, 4'h6, 2'b00, HOLD);
        req = 4'b0000;
        cyc("wrapdrain", 4'b0000, 4'h6, 2'b00, IDLE);

        // Reset to bring ptr back to 0 for the full rotation.
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        req = 4'b1111; out_ready = 1'b1;
        a = 4'h1; b = 4'h2; c = 4'h3; d = 4'h4;
        cyc("rr0", 4'b0001, 4'h1, 2'b00, HOLD);
        cyc("rr1", 4'b0010, 4'h2, 2'b10, HOLD);
        cyc("rr2", 4'b0100, 4'h3, 2'b01, HOLD);
        cyc("rr3", 4'b1000, 4'h4, 2'b11, HOLD);
        cyc("rr4", 4'b0001, 4'h1, 2'b00, HOLD);
        req = 4'b0000;
        cyc("rrdrain", 4'b0000, 4'h1, 2'b00, IDLE);

        // Stall: ptr=1, capture 0xA from requester 1, then wiggle inputs.
        out_ready = 1'b0; req = 4'b0010; b = 4'hA;
        cyc("stallcap", 4'b0010, 4'hA, 2'b10, HOLD);
        for (int i = 0; i < 5; i++) begin
            req = 4'($urandom_range(1, 15));
            a = 4'($urandom); b = 4'($urandom); c = 4'($urandom); d = 4'($urandom);
            cyc("stall", 4'b0000, 4'hA, 2'b10, HOLD);
        end
        out_ready = 1'b1; req = 4'b0100; c = 4'h5;
        cyc("unstall", 4'b0100, 4'h5, 2'b01, HOLD);

        // Asynchronous reset mid-HOLD, between clock edges.
        out_ready = 1'b0; req = 4'b0100;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.ov",  {7'h0, out_valid}, {7'h0, IDLE});
        chk("arst.y",   {4'h0, y},   8'h00);
        chk("arst.sel", {6'h0, sel}, 8'h00);
        chk("arst.gnt", {4'h0, gnt}, 8'h00);
        @(posedge clk);
        #1;
        chk("arst.hold", {7'h0, out_valid}, {7'h0, IDLE});
        rst_n = 1'b1; req = 4'b0010; b = 4'h7;
        cyc("post", 4'b0010, 4'h7, 2'b10, HOLD);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/fourx1mux_arbiter.md
FOURX1MUX_ARBITER -- requirements
Module: fourx1mux_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 4, width of each data input and of y.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port req, input, 4, request per requester; bit i belongs to requester i.
REQ-005 SHALL have ports a, b, c, d, input, DATA_WIDTH each, data of requesters 0, 1, 2, 3.
REQ-006 SHALL have port gnt, output, 4, one-hot grant pulse to the requester whose data is captured.
REQ-007 SHALL have port sel, output, 2, select code of the current or last granted requester.
REQ-008 SHALL have port y, output, DATA_WIDTH, registered shared-datapath output.
REQ-009 SHALL have port out_valid, output, 1, y holds an unconsumed word.
REQ-010 SHALL have port out_ready, input, 1, the downstream consumer accepts y.

Function
REQ-011 SHALL map requester index to sel code as: 0->2'b00, 1->2'b10, 2->2'b01, 3->2'b11.
REQ-012 SHALL arbitrate round-robin: search starts at pointer ptr (0..3), ascending index, wrapping 3->0; the first set req bit wins.
REQ-013 SHALL advance ptr to (winner+1) mod 4 on every capture; ptr is unchanged when nothing is captured.
REQ-014 SHALL define capture_en = (state==IDLE) | (out_ready & out_valid); a capture occurs when capture_en and |req.
REQ-015 SHALL, on capture, register the shared mux output into y, drive sel to the winner's code, pulse gnt[winner] high for exactly that cycle (combinational with capture), and set out_valid the next cycle.
REQ-016 SHALL give 1-cycle latency from a req sampled in IDLE to out_valid=1 with the selected data on y.
REQ-017 SHALL use a two-state FSM: IDLE (out_valid=0) and HOLD (out_valid=1).
REQ-018 SHALL transition IDLE->HOLD on capture; IDLE->IDLE otherwise.
REQ-019 SHALL transition HOLD->HOLD with new data on handshake plus capture (back-to-back, 1 word per cycle); HOLD->IDLE on handshake with req==0; HOLD->HOLD with y, sel unchanged while out_ready=0.
REQ-020 SHALL keep y and sel stable while out_valid=1 and out_ready=0, regardless of req or data input changes.
REQ-021 SHALL keep gnt=4'b0000 whenever no capture occurs, including throughout a stall.
REQ-022 SHALL ignore out_ready in IDLE.
REQ-023 SHALL never assert more than one gnt bit in any cycle.
REQ-024 SHALL let a requester holding req continuously be granted at most once per 4 captures when all 4 requesters are requesting.

Reset
REQ-025 SHALL, on rst_n low, immediately force state=IDLE, ptr=0, y=0, sel=2'b00, out_valid=0; gnt=0 during reset.
REQ-026 SHALL discard any held word when reset asserts mid-HOLD; no handshake completes for it.
REQ-027 SHALL perform the first capture no earlier than the first rising clk edge after rst_n deasserts.

Structure
REQ-028 SHALL place the FSM state encodings (IDLE, HOLD) and the index-to-sel code table in a shared package/header used by the block and bench.
REQ-029 SHALL instantiate the team's existing fourx1mux (DATA_WIDTH passed through) as its one sub-module for the datapath select; no duplicate mux logic.
REQ-030 SHALL contain arbitration, FSM, pointer and output register in this module only.

Verification
REQ-031 SHALL test: reset release, req=4'b0100, c=4'hC -> next cycle gnt=4'b0100 (capture cycle), then out_valid=1, y=4'hC, sel=2'b01.
REQ-032 SHALL test: req=4'b1111, out_ready=1 constant, a..d=1,2,3,4 -> grants 0,1,2,3,0 on consecutive cycles, y=1,2,3,4,1.
REQ-033 SHALL test: HOLD with y=4'hA, out_ready=0 for 5 cycles while inputs change -> y=4'hA, gnt=0, out_valid=1 throughout; out_ready=1 -> next capture.
REQ-034 SHALL test: ptr=3, req=4'b1001 -> requester 3 wins; next capture with req=4'b1001 -> requester 0 wins (wrap).
REQ-035 SHALL test: rst_n low asynchronously mid-HOLD -> out_valid=0, y=0, sel=00 without waiting for clk; after release, req=4'b0010 -> requester 1 granted first.
REQ-036 SHALL test: handshake with req=0 -> out_valid=0 next cycle, state IDLE, ptr unchanged.
